// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one synchronous memory port: round-robin grants with a
// bounded hold, registered readys and a tag pipeline that routes read data back to its requester.
// Optional macro MEM_ARB_ERR_EN adds an address-range check with a sticky err flag.
module mem_port_arbiter #(
    parameter int N          = 32,
    parameter int HOLD_MAX   = 8,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    input  logic         req0_wr_ena,
    input  logic [N-1:0] req0_addr,
    input  logic [N-1:0] req0_wr_data,
    output logic         req0_ready,
    output logic         req0_rd_valid,
    output logic [N-1:0] req0_rd_data,

    input  logic         req1_valid,
    input  logic         req1_wr_ena,
    input  logic [N-1:0] req1_addr,
    input  logic [N-1:0] req1_wr_data,
    output logic         req1_ready,
    output logic         req1_rd_valid,
    output logic [N-1:0] req1_rd_data,

    output logic         mem_wr_ena,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wr_data,
    input  logic [N-1:0] mem_rd_data,

    output logic         err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic owner;
        logic zero;
    } tag_t;

    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    state_t        state_reg, state_next;
    logic          last_owner_reg, last_owner_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

    logic          granted;
    logic          owner;
    logic          owner_valid;
    logic          owner_wr_ena;
    logic [N-1:0]  owner_addr;
    logic [N-1:0]  owner_wr_data;
    logic          other_valid;
    logic          accept;
    logic          addr_bad;

    tag_t          tag_in;
    tag_t          tag_out;

    // Owner view of the current grant; everything downstream is muxed from here.
    assign granted       = (state_reg != IDLE);
    assign owner         = (state_reg == GRANT1);
    assign owner_valid   = granted && (owner ? req1_valid : req0_valid);
    assign owner_wr_ena  = owner ? req1_wr_ena : req0_wr_ena;
    assign owner_addr    = granted ? (owner ? req1_addr : req0_addr) : '0;
    assign owner_wr_data = granted ? (owner ? req1_wr_data : req0_wr_data) : '0;
    assign other_valid   = owner ? req0_valid : req1_valid;
    assign accept        = owner_valid;

    assign req0_ready = (state_reg == GRANT0);
    assign req1_ready = (state_reg == GRANT1);

`ifdef MEM_ARB_ERR_EN
    logic err_reg;

    assign addr_bad = (owner_addr >= N'(ADDR_LIMIT));
    assign err      = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept && addr_bad) begin
            err_reg <= 1'b1;
        end
    end
`else
    assign addr_bad = 1'b0;
    assign err      = 1'b0;
`endif

    assign mem_addr    = owner_addr;
    assign mem_wr_data = owner_wr_data;
    assign mem_wr_ena  = accept && owner_wr_ena && !addr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            hold_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        hold_cnt_next   = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                hold_cnt_next = '0;
                if (req0_valid && req1_valid) begin
                    state_next = last_owner_reg ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (owner_valid) begin
                    // The hold limit only bites when the other side is actually waiting.
                    if (other_valid && (hold_cnt_reg == HOLD_LAST)) begin
                        state_next      = owner ? GRANT0 : GRANT1;
                        last_owner_next = owner;
                        hold_cnt_next   = '0;
                    end else if (hold_cnt_reg != HOLD_LAST) begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end else if (other_valid) begin
                    state_next      = owner ? GRANT0 : GRANT1;
                    last_owner_next = owner;
                    hold_cnt_next   = '0;
                end else begin
                    state_next      = IDLE;
                    last_owner_next = owner;
                    hold_cnt_next   = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    // Return tags ride alongside the memory latency, so they survive grant switches.
    assign tag_in = '{valid: accept && !owner_wr_ena, owner: owner, zero: addr_bad};

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
            tag_t stage_in;
            tag_t stage_reg;
            if (gi == 0) begin : g_first
                assign stage_in = tag_in;
            end else begin : g_chain
                assign stage_in = g_tag[gi-1].stage_reg;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign tag_out = g_tag[RD_LATENCY-1].stage_reg;

    assign req0_rd_valid = tag_out.valid && !tag_out.owner;
    assign req1_rd_valid = tag_out.valid &&  tag_out.owner;
    assign req0_rd_data  = (req0_rd_valid && !tag_out.zero) ? mem_rd_data : '0;
    assign req1_rd_data  = (req1_rd_valid && !tag_out.zero) ? mem_rd_data : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous memory port (wr_ena/addr/din/dout, 1-cycle read latency) between two requesters.
- Requester 0 is the mips_core load/store/fetch port. Requester 1 is a loader/debug/DMA master.
- Sits between the requesters and port 0 of synth_dual_port_memory. Grants are round-robin with a bounded hold so that neither requester can starve the other.

Parameters:
- N, 32, data and address width.
- HOLD_MAX, 8, maximum consecutive accepted transfers by one owner while the other requester is waiting.
- RD_LATENCY, 1, memory read latency in cycles; it sets the depth of the return-tag pipeline.
- ADDR_LIMIT, 1024, first illegal word address. Used only with MEM_ARB_ERR_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an access pending.
- req0_wr_ena  in  1  1 = write, 0 = read.
- req0_addr  in  N  word address.
- req0_wr_data  in  N  write data.
- req0_ready  out  1  requester 0 owns the port; the transfer is accepted when valid&&ready.
- req0_rd_valid  out  1  read data for requester 0 is on req0_rd_data this cycle.
- req0_rd_data  out  N  returned read data; 0 when req0_rd_valid=0.
- req1_valid, req1_wr_ena, req1_addr, req1_wr_data, req1_ready, req1_rd_valid, req1_rd_data: same as requester 0.
- mem_wr_ena  out  1  to memory wr_ena0.
- mem_addr  out  N  to memory addr0.
- mem_wr_data  out  N  to memory din0.
- mem_rd_data  in  N  from memory dout0.
- err  out  1  sticky address-range error; tied 0 without MEM_ARB_ERR_EN.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, last_owner=1 (so requester 0 wins first), hold_cnt=0, return pipeline cleared, err=0.
  - All outputs 0: readys, rd_valids, rd_data, mem_wr_ena, mem_addr, mem_wr_data.
  - Reads in flight at reset are dropped; no rd_valid is produced for them.
- States: IDLE, GRANT0, GRANT1.
  - reqX_ready = (state==GRANTX). It is registered and never depends combinationally on valid.
- IDLE transitions:
  - Only one valid: go to that requester's GRANT.
  - Both valid: go to the GRANT of the requester that is not last_owner.
  - Neither valid: stay in IDLE.
  - Cost: one bubble cycle from IDLE to the first accept.
- GRANTx transitions:
  - Owner valid and (other not valid, or hold_cnt < HOLD_MAX-1, or this cycle is not an accept): stay.
  - Owner accepts its HOLD_MAX-th consecutive transfer while the other is valid: go to GRANTother next cycle.
  - Owner not valid and other valid: go to GRANTother directly, no IDLE.
  - Neither valid: go to IDLE.
  - Every switch sets last_owner=old owner and hold_cnt=0.
- hold_cnt:
  - Increments per accept, saturating at HOLD_MAX-1.
  - While the other requester is idle, the owner keeps the grant indefinitely.
- Memory drive (combinational from the owner):
  - mem_addr and mem_wr_data follow the owner's request; 0 in IDLE.
  - mem_wr_ena = owner_valid && owner_wr_ena && ready. A write commits on the edge that ends the accept cycle.
- Read return:
  - An accepted read pushes tag {1, owner} into the RD_LATENCY-deep pipeline.
  - When the tag emerges, the matching reqX_rd_valid=1 and reqX_rd_data=mem_rd_data for one cycle. Data for an accept in cycle t appears in cycle t+RD_LATENCY.
  - Tags survive owner switches; no returns are lost or misrouted across a switch.
- Writes produce no rd_valid.
- At most one memory access per cycle. Back-to-back accepts by the same owner give one transfer per cycle.

Optional Feature:
- MEM_ARB_ERR_EN defined:
  - An accepted access with addr >= ADDR_LIMIT is still accepted (ready handshake unchanged).
  - Its write is suppressed (mem_wr_ena=0).
  - Its read returns rd_valid=1 with rd_data=0.
  - err is set and stays 1 until rst.
- MEM_ARB_ERR_EN undefined: no range check, err held 0, all accesses reach memory.

Test Plan:
- Reset, then req0 read addr 4 (DMEM[4]=0xDEADBEEF) from IDLE:
  - req0_ready=1 at cycle 1.
  - req0_rd_valid=1 with 0xDEADBEEF at cycle 2.
  - req1 outputs stay 0.
- Both valid from IDLE right after reset:
  - GRANT0 first.
  - req0 streams writes 0..9 continuously: after 8 accepts, GRANT1 for req1's read.
  - req0 regains the grant when req1 drops.
- req0 read addr 8 accepted, then req0 drops valid the same cycle req1 valid:
  - GRANT1 next cycle with no IDLE gap.
  - req0_rd_valid still returns DMEM[8]; req1_rd_valid=0.
- req1 writes 0x12345678 to addr 20, then reads addr 20 → req1_rd_data=0x12345678. Only requester 1's valid is asserted; req1 keeps the grant beyond 8 accepts.
- Assert rst for one cycle one cycle after a req0 read accept:
  - No rd_valid follows.
  - state=IDLE and all outputs 0 immediately (asynchronous).
- With MEM_ARB_ERR_EN, req1 writes addr 1024 then reads addr 1024:
  - Memory is unchanged.
  - The read returns rd_valid=1 with data 0.
  - err=1 and stays 1 until rst.
